// File: rtl/scratchpad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scratchpad_pkg
//  Purpose  : Shared definitions for the scratchpad and its sequencers:
//             default width constants and the read-controller state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package scratchpad_pkg;

   // Default geometry shared with the scratchpad storage itself
   localparam int SP_DATA_WIDTH = 16;
   localparam int SP_ADDR_WIDTH = 4;
   localparam int SP_DEPTH      = 16;

   // Read-controller state encoding
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STREAM = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;
   localparam logic [1:0] FINISH = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = IDLE,
      S_STREAM = STREAM,
      S_DRAIN  = DRAIN,
      S_FINISH = FINISH
   } rd_state_t;

endpackage : scratchpad_pkg
`default_nettype wire

// File: rtl/scratchpad_addr_wrap.sv
`default_nettype none
// ============================================================================
//  Module   : scratchpad_addr_wrap
//  Purpose  : Combinational modulo-DEPTH address step: next = (addr+inc) mod
//             DEPTH, valid for addr < DEPTH and inc < DEPTH.
//  Ports    : addr      in  ADDR_WIDTH  current address
//             inc       in  ADDR_WIDTH  increment
//             next_addr out ADDR_WIDTH  wrapped next address
//  Revision : 1.0 - initial release
// ============================================================================
module scratchpad_addr_wrap
   import scratchpad_pkg::*;
#(
   parameter int ADDR_WIDTH = SP_ADDR_WIDTH,
   parameter int DEPTH      = SP_DEPTH
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [ADDR_WIDTH-1:0] inc,
   output logic [ADDR_WIDTH-1:0] next_addr
);

   localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

   // One extra bit so addr+inc cannot overflow before the wrap compare
   logic [ADDR_WIDTH:0] w_sum;

   assign w_sum     = {1'b0, addr} + {1'b0, inc};
   assign next_addr = (w_sum >= c_DEPTH) ? ADDR_WIDTH'(w_sum - c_DEPTH)
                                         : ADDR_WIDTH'(w_sum);

endmodule : scratchpad_addr_wrap
`default_nettype wire

// File: rtl/scratchpad_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : scratchpad_stream_reader
//  Purpose  : Read-side controller for the register-type scratchpad. Sweeps
//             raddr over a programmed burst (wrapping at DEPTH), registers the
//             combinational read data and presents it as a valid/ready stream.
//  Config   : SCRATCHPAD_READER_STRIDE_EN - adds the stride port; otherwise
//             the address increment is the constant 1.
//  Ports    : clk, rst (async, active high)
//             start, start_addr, len, [stride]  - burst command
//             raddr, rdata                      - scratchpad read port
//             out_data, out_valid, out_ready    - output stream
//             busy, done                        - status
//  Revision : 1.0 - initial release
// ============================================================================
module scratchpad_stream_reader
   import scratchpad_pkg::*;
#(
   parameter int DATA_WIDTH = SP_DATA_WIDTH,
   parameter int ADDR_WIDTH = SP_ADDR_WIDTH,
   parameter int DEPTH      = SP_DEPTH,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [LEN_WIDTH-1:0]  len,
`ifdef SCRATCHPAD_READER_STRIDE_EN
   input  logic [ADDR_WIDTH-1:0] stride,
`endif
   output logic [ADDR_WIDTH-1:0] raddr,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   rd_state_t             r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]  r_remaining;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_valid;
   logic                  r_busy;
   logic                  r_done;

   logic [ADDR_WIDTH-1:0] w_inc;
   logic [ADDR_WIDTH-1:0] w_next_addr;
   logic                  w_load;

`ifdef SCRATCHPAD_READER_STRIDE_EN
   assign w_inc = stride;
`else
   assign w_inc = ADDR_WIDTH'(1);
`endif

   scratchpad_addr_wrap #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_addr_wrap (
      .addr      (r_addr),
      .inc       (w_inc),
      .next_addr (w_next_addr)
   );

   // Output register may take a new word when empty or being drained this cycle
   assign w_load = (r_state == S_STREAM) && (!r_out_valid || out_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_busy <= 1'b1;
                  if (len != '0) begin
                     r_addr      <= start_addr;
                     r_remaining <= len;
                     r_state     <= S_STREAM;
                  end else begin
                     r_state <= S_FINISH;
                  end
               end
            end
            S_STREAM: begin
               if (w_load) begin
                  r_out_data  <= rdata;
                  r_out_valid <= 1'b1;
                  r_addr      <= w_next_addr;
                  r_remaining <= r_remaining - LEN_WIDTH'(1);
                  if (r_remaining == LEN_WIDTH'(1)) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (r_out_valid && out_ready) begin
                  r_out_valid <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= S_FINISH;
               end
            end
            S_FINISH: begin
               // Arrival from DRAIN already raised done. An empty burst
               // arrives with done low and spends one extra cycle here, so
               // done lands one cycle after the command edge.
               if (r_done) begin
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_done <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign raddr     = r_addr;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule : scratchpad_stream_reader
`default_nettype wire
